// File: rtl/fsm_multi_pkg.sv
// Shared types for the multi-FIFO control FSM: state encoding and packed-slice helper.
package fsm_multi_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  // LSB position of FIFO idx inside a packed per-FIFO bus of the given width.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fsm_idle_qual.sv
// Idle qualifier: counts consecutive all-empty samples while enabled and pulses
// on the IDLE_DLY-th one. The counter saturates and clears whenever the run breaks.
module fsm_idle_qual
  import fsm_multi_pkg::*;
#(
  parameter int unsigned IDLE_DLY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic all_empty,
  output logic qual
);

  localparam int unsigned CntW = $clog2(IDLE_DLY + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(IDLE_DLY);
  localparam logic [CntW-1:0] QualCnt = CntW'(IDLE_DLY - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: increment (saturating) on an enabled all-empty sample, else clear.
  always_comb begin
    cnt_d = '0;
    if (enable && all_empty) begin
      cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign qual = enable && all_empty && (cnt_q == QualCnt);

endmodule

// File: rtl/fsm_multi_ctrl.sv
// Multi-FIFO supervisor FSM: programs per-FIFO thresholds in INIT, validates them,
// qualifies idle entry and captures sticky per-FIFO errors.
// Optional macro FSM_ERR_RECOVER_EN: allows ERROR -> INIT on init with no errors,
// clearing error_src and cfg_err on that edge. Without it ERROR exits only by reset.
module fsm_multi_ctrl
  import fsm_multi_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 5,
  parameter int unsigned TW        = 5,
  parameter int unsigned IDLE_DLY  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [NUM_FIFOS*TW-1:0] thr_low_in,
  input  logic [NUM_FIFOS*TW-1:0] thr_high_in,
  input  logic [NUM_FIFOS-1:0]    empties,
  input  logic [NUM_FIFOS-1:0]    errors,
  output logic [NUM_FIFOS*TW-1:0] thr_low_out,
  output logic [NUM_FIFOS*TW-1:0] thr_high_out,
  output logic [STATE_W-1:0]      state_out,
  output logic                    init_out,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out,
  output logic [NUM_FIFOS-1:0]    error_src,
  output logic                    cfg_err
);

  state_e                  state_q, state_d;
  logic [NUM_FIFOS*TW-1:0] thr_low_q, thr_low_d, thr_high_q, thr_high_d;
  logic [NUM_FIFOS-1:0]    err_src_q, err_src_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    init_q, idle_q, active_q, error_q;
  logic                    bad_pair, all_empty, any_err, idle_qual;

  assign all_empty = &empties;
  assign any_err   = |errors;

  fsm_idle_qual #(
    .IDLE_DLY (IDLE_DLY)
  ) u_idle_qual (
    .clk       (clk),
    .reset     (reset),
    .enable    (state_q == StActive),
    .all_empty (all_empty),
    .qual      (idle_qual)
  );

  // Unsigned low <= high check on every FIFO pair; equality is legal.
  always_comb begin
    bad_pair = 1'b0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (thr_low_in[slice_lsb(i, TW) +: TW] > thr_high_in[slice_lsb(i, TW) +: TW]) begin
        bad_pair = 1'b1;
      end
    end
  end

  // Next state, threshold load and sticky capture; errors outrank init and validation.
  always_comb begin
    state_d    = state_q;
    cfg_err_d  = cfg_err_q;
    err_src_d  = err_src_q;
    thr_low_d  = thr_low_q;
    thr_high_d = thr_high_q;

    if (state_q != StReset) begin
      err_src_d = err_src_q | errors;
    end
    if (state_q == StInit) begin
      thr_low_d  = thr_low_in;
      thr_high_d = thr_high_in;
    end

    unique case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        if (any_err) begin
          state_d = StError;
        end else if (!init) begin
          if (bad_pair) begin
            state_d   = StError;
            cfg_err_d = 1'b1;
          end else if (all_empty) begin
            state_d = StIdle;
          end else begin
            state_d = StActive;
          end
        end
      end
      StIdle: begin
        if (any_err)         state_d = StError;
        else if (init)       state_d = StInit;
        else if (!all_empty) state_d = StActive;
      end
      StActive: begin
        if (any_err)        state_d = StError;
        else if (init)      state_d = StInit;
        else if (idle_qual) state_d = StIdle;
      end
      StError: begin
`ifdef FSM_ERR_RECOVER_EN
        if (init && !any_err) begin
          state_d   = StInit;
          err_src_d = '0;
          cfg_err_d = 1'b0;
        end
`endif
      end
      default: state_d = StReset;
    endcase
  end

  // State, thresholds, sticky flags and decoded one-hot flags, all registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StReset;
      thr_low_q  <= '0;
      thr_high_q <= '0;
      err_src_q  <= '0;
      cfg_err_q  <= 1'b0;
      init_q     <= 1'b0;
      idle_q     <= 1'b0;
      active_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_low_q  <= thr_low_d;
      thr_high_q <= thr_high_d;
      err_src_q  <= err_src_d;
      cfg_err_q  <= cfg_err_d;
      init_q     <= (state_d == StInit);
      idle_q     <= (state_d == StIdle);
      active_q   <= (state_d == StActive);
      error_q    <= (state_d == StError);
    end
  end

  assign state_out    = state_q;
  assign thr_low_out  = thr_low_q;
  assign thr_high_out = thr_high_q;
  assign error_src    = err_src_q;
  assign cfg_err      = cfg_err_q;
  assign init_out     = init_q;
  assign idle_out     = idle_q;
  assign active_out   = active_q;
  assign error_out    = error_q;

endmodule

// File: tb/tb_fsm_multi_ctrl.sv
// Directed bench for fsm_multi_ctrl at default parameters (5 FIFOs, TW=5, IDLE_DLY=4).
module tb_fsm_multi_ctrl;

  localparam int unsigned N  = 5;
  localparam int unsigned TW = 5;

  localparam logic [2:0] S_RESET = 3'd0, S_INIT = 3'd1, S_IDLE = 3'd2, S_ACTIVE = 3'd3,
                         S_ERROR = 3'd4;

  logic            clk = 1'b0;
  logic            reset, init;
  logic [N*TW-1:0] thr_low_in, thr_high_in, thr_low_out, thr_high_out;
  logic [N-1:0]    empties, err_in, error_src;
  logic [2:0]      state_out;
  logic            init_out, idle_out, active_out, error_out, cfg_err;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [N*TW-1:0] LowOk   = {5{5'd2}};
  localparam logic [N*TW-1:0] HighOk  = {5{5'd10}};
  localparam logic [N*TW-1:0] LowBad  = {5'd2, 5'd20, 5'd2, 5'd2, 5'd2};
  localparam logic [N*TW-1:0] HighBad = {5'd10, 5'd5, 5'd10, 5'd10, 5'd10};

  fsm_multi_ctrl #(
    .NUM_FIFOS (N),
    .TW        (TW),
    .IDLE_DLY  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .thr_low_in   (thr_low_in),
    .thr_high_in  (thr_high_in),
    .empties      (empties),
    .errors       (err_in),
    .thr_low_out  (thr_low_out),
    .thr_high_out (thr_high_out),
    .state_out    (state_out),
    .init_out     (init_out),
    .idle_out     (idle_out),
    .active_out   (active_out),
    .error_out    (error_out),
    .error_src    (error_src),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_active();
    reset = 1'b0; init = 1'b0; err_in = '0; empties = 5'h1E;
    thr_low_in = LowOk; thr_high_in = HighOk;
    tick();
    reset = 1'b1; init = 1'b1;
    tick();
    tick();
    init = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; err_in = '0; empties = '0;
    thr_low_in = LowOk; thr_high_in = HighOk;
    tick();
    tick();
    n_chk++;
    if ({state_out, init_out, idle_out, active_out, error_out} !== {S_RESET, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_state: got %0d/%b want 0/0000", state_out,
               {init_out, idle_out, active_out, error_out});
    end
    n_chk++;
    if ({thr_low_out, thr_high_out, error_src, cfg_err} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: got %h %h %b %b want all zero", thr_low_out, thr_high_out,
               error_src, cfg_err);
    end
    reset = 1'b1; init = 1'b1;
    tick();
    n_chk++;
    if ({state_out, init_out} !== {S_INIT, 1'b1}) begin
      n_err++;
      $display("FAIL reset_to_init: got %0d/%b want 1/1", state_out, init_out);
    end
    tick();
    n_chk++;
    if (thr_low_out !== LowOk || thr_high_out !== HighOk) begin
      n_err++;
      $display("FAIL thr_load: got %h %h want %h %h", thr_low_out, thr_high_out, LowOk, HighOk);
    end
    init = 1'b0; empties = 5'h1F;
    tick();
    n_chk++;
    if ({state_out, idle_out, active_out} !== {S_IDLE, 2'b10}) begin
      n_err++;
      $display("FAIL init_to_idle: got %0d/%b%b want 2/10", state_out, idle_out, active_out);
    end
  endtask

  task automatic test_idle_qual();
    empties = 5'h1E;
    tick();
    n_chk++;
    if ({state_out, active_out} !== {S_ACTIVE, 1'b1}) begin
      n_err++;
      $display("FAIL idle_to_active: got %0d/%b want 3/1", state_out, active_out);
    end
    empties = 5'h1F;
    repeat (3) tick();
    empties = 5'h1E;
    tick();
    n_chk++;
    if (state_out !== S_ACTIVE) begin
      n_err++;
      $display("FAIL idle_broken_run: got %0d want 3", state_out);
    end
    empties = 5'h1F;
    repeat (3) tick();
    n_chk++;
    if (state_out !== S_ACTIVE) begin
      n_err++;
      $display("FAIL idle_early: got %0d want 3", state_out);
    end
    tick();
    n_chk++;
    if ({state_out, idle_out} !== {S_IDLE, 1'b1}) begin
      n_err++;
      $display("FAIL idle_qualified: got %0d/%b want 2/1", state_out, idle_out);
    end
  endtask

  task automatic test_error_capture();
    go_active();
    err_in = 5'b00100;
    tick();
    n_chk++;
    if ({state_out, error_out, error_src} !== {S_ERROR, 1'b1, 5'b00100}) begin
      n_err++;
      $display("FAIL err_first: got %0d/%b/%b want 4/1/00100", state_out, error_out, error_src);
    end
    err_in = 5'b01000;
    tick();
    n_chk++;
    if (error_src !== 5'b01100) begin
      n_err++;
      $display("FAIL err_sticky: got %b want 01100", error_src);
    end
    err_in = '0; init = 1'b1;
    tick();
    init = 1'b0;
`ifdef FSM_ERR_RECOVER_EN
    n_chk++;
    if ({state_out, error_src} !== {S_INIT, 5'b00000}) begin
      n_err++;
      $display("FAIL err_recover: got %0d/%b want 1/00000", state_out, error_src);
    end
`else
    n_chk++;
    if ({state_out, error_src} !== {S_ERROR, 5'b01100}) begin
      n_err++;
      $display("FAIL err_absorb: got %0d/%b want 4/01100", state_out, error_src);
    end
`endif
  endtask

  task automatic test_thr_validation();
    reset = 1'b0; init = 1'b0; err_in = '0; empties = 5'h1F;
    tick();
    reset = 1'b1; init = 1'b1; thr_low_in = LowBad; thr_high_in = HighBad;
    tick();
    tick();
    init = 1'b0;
    tick();
    n_chk++;
    if ({state_out, cfg_err, error_src} !== {S_ERROR, 1'b1, 5'b00000}) begin
      n_err++;
      $display("FAIL cfg_invalid: got %0d/%b/%b want 4/1/00000", state_out, cfg_err, error_src);
    end
    n_chk++;
    if (thr_low_out !== LowBad || thr_high_out !== HighBad) begin
      n_err++;
      $display("FAIL cfg_debug_load: got %h %h want %h %h", thr_low_out, thr_high_out, LowBad,
               HighBad);
    end
    // Equal low/high is a valid pair.
    reset = 1'b0;
    tick();
    reset = 1'b1; init = 1'b1; thr_low_in = {5{5'd7}}; thr_high_in = {5{5'd7}};
    tick();
    init = 1'b0;
    tick();
    n_chk++;
    if ({state_out, cfg_err} !== {S_IDLE, 1'b0}) begin
      n_err++;
      $display("FAIL cfg_equal: got %0d/%b want 2/0", state_out, cfg_err);
    end
  endtask

  task automatic test_priority();
    go_active();
    init = 1'b1; err_in = 5'b00001;
    tick();
    n_chk++;
    if ({state_out, error_src, cfg_err} !== {S_ERROR, 5'b00001, 1'b0}) begin
      n_err++;
      $display("FAIL prio_err_over_init: got %0d/%b/%b want 4/00001/0", state_out, error_src,
               cfg_err);
    end
    err_in = '0;
    tick();
    init = 1'b0;
`ifdef FSM_ERR_RECOVER_EN
    n_chk++;
    if ({state_out, init_out, error_src} !== {S_INIT, 1'b1, 5'b00000}) begin
      n_err++;
      $display("FAIL prio_recover: got %0d/%b/%b want 1/1/00000", state_out, init_out, error_src);
    end
`else
    n_chk++;
    if ({state_out, error_src} !== {S_ERROR, 5'b00001}) begin
      n_err++;
      $display("FAIL prio_no_recover: got %0d/%b want 4/00001", state_out, error_src);
    end
`endif
  endtask

  task automatic test_mid_reset();
    go_active();
    empties = 5'h1F;
    repeat (2) tick();
    reset = 1'b0; err_in = 5'b10000;
    tick();
    n_chk++;
    if ({state_out, init_out, idle_out, active_out, error_out, error_src, cfg_err,
         thr_low_out, thr_high_out} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got state %0d src %b thr %h %h want all zero", state_out,
               error_src, thr_low_out, thr_high_out);
    end
    // Errors seen while in RESET are not captured.
    reset = 1'b1;
    tick();
    n_chk++;
    if ({state_out, error_src} !== {S_INIT, 5'b00000}) begin
      n_err++;
      $display("FAIL reset_no_capture: got %0d/%b want 1/00000", state_out, error_src);
    end
    err_in = '0;
  endtask

  initial begin
    test_reset();
    test_idle_qual();
    test_error_capture();
    test_thr_validation();
    test_priority();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fsm_multi_ctrl.md
# fsm_multi_ctrl

Parametrised successor to the link-layer control FSM. Supervises NUM_FIFOS FIFOs and programs their low/high almost-full/empty thresholds during INIT. Reports a one-hot activity status (idle/active/error) plus sticky per-FIFO error capture. Adds threshold validation, qualified idle entry and a configurable error-recovery path.

## Interface
- NUM_FIFOS, 5: number of supervised FIFOs, ≥1.
- TW, 5: threshold width in bits.
- IDLE_DLY, 4: consecutive all-empty cycles required for ACTIVE→IDLE, ≥1.
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-low; clears everything on a sampled clk edge.
- init  in  1: request (re)programming of thresholds.
- thr_low_in  in  NUM_FIFOS*TW: packed low thresholds; FIFO i at [i*TW +: TW].
- thr_high_in  in  NUM_FIFOS*TW: packed high thresholds; same packing.
- empties  in  NUM_FIFOS: per-FIFO empty flags.
- errors  in  NUM_FIFOS: per-FIFO error pulses or levels.
- thr_low_out  out  NUM_FIFOS*TW: registered programmed low thresholds.
- thr_high_out  out  NUM_FIFOS*TW: registered programmed high thresholds.
- state_out  out  3: current state encoding.
- init_out, idle_out, active_out, error_out  out  1 each: registered state flags, one-hot with state_out.
- error_src  out  NUM_FIFOS: sticky OR of errors sampled outside RESET.
- cfg_err  out  1: sticky flag for an invalid threshold pair.

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Per-cycle priority: reset > errors > init > empties/idle qualification.
- reset==0: state RESET. All outputs 0, including thresholds, error_src, cfg_err and the idle counter.
- RESET: moves to INIT on the first edge with reset==1.
- INIT:
  - thr_*_out load thr_*_in on every edge spent in INIT, including the exit edge.
  - When init==0, validate each pair, unsigned, equality allowed:
    - any thr_low_in[i] > thr_high_in[i] → ERROR, cfg_err=1;
    - else all empties set → IDLE;
    - else → ACTIVE.
- ACTIVE:
  - Idle counter increments while &empties and clears otherwise.
  - Moves to IDLE on the edge where the counter equals IDLE_DLY-1 and &empties, i.e. the IDLE_DLY-th consecutive all-empty sample.
- IDLE:
  - Any empties bit low → ACTIVE on the next edge; the counter is cleared.
- IDLE or ACTIVE with init==1 → INIT.
- Errors:
  - In any state other than RESET, |errors moves the FSM to ERROR.
  - error_src |= errors on every such edge.
  - Errors take priority over init and over validation.
- ERROR: absorbing until reset, unless FSM_ERR_RECOVER_EN is compiled in (see Configuration).
- thr_*_out hold their value in every state except INIT.
- All arithmetic is unsigned. Counter width is $clog2(IDLE_DLY+1) and the counter saturates; it never wraps.

## Timing
- Fully registered Moore outputs. Inputs sampled at edge k are reflected on the state, flags and error_src after edge k (1-cycle latency).
- Threshold outputs lag thr_*_in by exactly one edge while in INIT.
- errors asserted for a single cycle is sufficient: capture is on that edge.
- reset asserted mid-operation, including in ERROR or during idle qualification, produces the reset state at that edge.
- Simultaneous init and errors: ERROR wins.
- Simultaneous init exit and an invalid threshold pair: ERROR. thr_*_out still load the invalid values for debug.

## Configuration
- FSM_ERR_RECOVER_EN defined:
  - ERROR with init==1 and errors==0 → INIT.
  - error_src and cfg_err clear on that edge.
- FSM_ERR_RECOVER_EN undefined:
  - ERROR is exited only by reset; init is ignored in ERROR.

## Structure
- Package fsm_multi_pkg holds the state localparams/enum, STATE_W=3, and a helper function for the packed-slice index.
- Sub-module fsm_idle_qual:
  - Inputs: clk, reset, enable (state==ACTIVE), all_empty.
  - Output: qualified pulse.
  - Holds the idle counter and saturation logic.
- Top level holds the state register, threshold registers, validation comparators and sticky capture.

## Test plan
Defaults NUM_FIFOS=5, TW=5, IDLE_DLY=4.
- Reset then init: reset=0 for 2 cycles, then reset=1 with init=1, thr_low_in all 5'd2, thr_high_in all 5'd10. Then init=0 with empties=5'h1F → after the edge, thr_*_out match the inputs and state=IDLE.
- Idle qualification: from ACTIVE, empties=5'h1F for 3 cycles then 5'h1E → no IDLE. Then 4 consecutive cycles of 5'h1F → IDLE after the 4th edge.
- Error capture: in ACTIVE, errors=5'b00100 for 1 cycle, then 5'b01000 → error_src=5'b00100 then 5'b01100. State=ERROR; init is ignored without the macro.
- Threshold validation: in INIT, FIFO 3 low=5'd20, high=5'd5, then init=0 → state=ERROR, cfg_err=1, error_src=0.
- Priority and recovery: init=1 and errors=5'b00001 on the same edge → ERROR. With FSM_ERR_RECOVER_EN defined, then init=1 with errors=0 → INIT, error_src=0.
- Mid-run reset: reset=0 during ACTIVE with the counter at 2 → all outputs 0 and state=RESET on that edge.
